// File: rtl/mem_access_unit.sv
// Load/store unit: aligns requests onto the memory port, waits for mem_resp, returns extended load data.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses return an error instead of being rounded down.
module mem_access_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic [XLEN-1:0]   mem_address,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_byte_enable,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_resp,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    // Counter only needs to hold 0..TIMEOUT-1
    localparam int unsigned CNTW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nx;
    logic              ready_nx, rd_nx, wr_nx, rv_nx, err_nx;
    logic [XLEN-1:0]   addr_nx, wdata_nx, rdata_nx;
    logic [NB-1:0]     be_nx;
    logic [OFFW-1:0]   off_q, off_nx;
    logic [2:0]        f3_q, f3_nx;
    logic              write_q, write_nx;
    logic [CNTW-1:0]   cnt, cnt_nx;

    logic [OFFW-1:0]   req_off, size_mask, off_eff;
    logic [NB-1:0]     be_base, be_req;
    logic [XLEN-1:0]   wdata_sh;
    logic              legal, trap;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              misaligned;
`endif

    logic [XLEN-1:0]   rd_sh, rd_mask, rd_ext;
    logic              rd_sign;

    // Request decode: legality, lane offset, byte enables and shifted store data
    always_comb begin
        req_off = req_addr[OFFW-1:0];
        case (req_funct3[1:0])
            2'd0:    begin size_mask = OFFW'(0); be_base = NB'(8'h01); end
            2'd1:    begin size_mask = OFFW'(1); be_base = NB'(8'h03); end
            2'd2:    begin size_mask = OFFW'(3); be_base = NB'(8'h0F); end
            default: begin size_mask = OFFW'(7); be_base = NB'(8'hFF); end
        endcase
        if (req_write) begin
            legal = !req_funct3[2] && ((XLEN == 64) || (req_funct3[1:0] != 2'd3));
        end else begin
            legal = (req_funct3 != 3'b111) &&
                    ((XLEN == 64) || ((req_funct3 != 3'b011) && (req_funct3 != 3'b110)));
        end
        off_eff  = req_off & ~size_mask;
        be_req   = be_base << off_eff;
        wdata_sh = req_wdata << {off_eff, 3'b000};
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = |(req_off & size_mask);
        trap       = !legal || misaligned;
`else
        trap       = !legal;
`endif
    end

    // Load extraction from the latched lane offset and funct3
    always_comb begin
        rd_sh = mem_rdata >> {off_q, 3'b000};
        case (f3_q[1:0])
            2'd0:    begin rd_mask = XLEN'(8'hFF);         rd_sign = rd_sh[7];      end
            2'd1:    begin rd_mask = XLEN'(16'hFFFF);      rd_sign = rd_sh[15];     end
            2'd2:    begin rd_mask = XLEN'(32'hFFFF_FFFF); rd_sign = rd_sh[31];     end
            default: begin rd_mask = '1;                   rd_sign = rd_sh[XLEN-1]; end
        endcase
        rd_ext = (rd_sh & rd_mask) | ((rd_sign && !f3_q[2]) ? ~rd_mask : '0);
    end

    // Next state and next registered outputs
    always_comb begin
        state_nx = state;
        ready_nx = req_ready;
        addr_nx  = mem_address;
        wdata_nx = mem_wdata;
        be_nx    = mem_byte_enable;
        rd_nx    = mem_read;
        wr_nx    = mem_write;
        rv_nx    = 1'b0;
        rdata_nx = rsp_rdata;
        err_nx   = rsp_err;
        off_nx   = off_q;
        f3_nx    = f3_q;
        write_nx = write_q;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                ready_nx = 1'b1;
                rdata_nx = '0;
                err_nx   = 1'b0;
                if (req_valid) begin
                    ready_nx = 1'b0;
                    off_nx   = off_eff;
                    f3_nx    = req_funct3;
                    write_nx = req_write;
                    if (trap) begin
                        state_nx = RESP;
                        rv_nx    = 1'b1;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = ACCESS;
                        addr_nx  = {req_addr[XLEN-1:OFFW], OFFW'(0)};
                        wdata_nx = req_write ? wdata_sh : '0;
                        be_nx    = be_req;
                        rd_nx    = !req_write;
                        wr_nx    = req_write;
                        cnt_nx   = '0;
                    end
                end
            end
            ACCESS: begin
                // A response on the expiry cycle takes priority over the timeout
                if (mem_resp || ((TIMEOUT != 0) && (cnt == CNT_LAST))) begin
                    state_nx = RESP;
                    rv_nx    = 1'b1;
                    err_nx   = !mem_resp;
                    rdata_nx = (mem_resp && !write_q) ? rd_ext : '0;
                    addr_nx  = '0;
                    wdata_nx = '0;
                    be_nx    = '0;
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                end else begin
                    cnt_nx = cnt + CNTW'(1);
                end
            end
            RESP: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
                rdata_nx = '0;
                err_nx   = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            off_q           <= '0;
            f3_q            <= '0;
            write_q         <= 1'b0;
            cnt             <= '0;
        end else begin
            state           <= state_nx;
            req_ready       <= ready_nx;
            mem_address     <= addr_nx;
            mem_wdata       <= wdata_nx;
            mem_byte_enable <= be_nx;
            mem_read        <= rd_nx;
            mem_write       <= wr_nx;
            rsp_valid       <= rv_nx;
            rsp_rdata       <= rdata_nx;
            rsp_err         <= err_nx;
            off_q           <= off_nx;
            f3_q            <= f3_nx;
            write_q         <= write_nx;
            cnt             <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit instance (default timeout) and a 64-bit instance (timeout 4).
module tb_mem_access_unit;

    localparam int unsigned TO64 = 4;

    typedef struct packed {
        logic        ready;
        logic        rd;
        logic        wr;
        logic        rv;
        logic        err;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [7:0]  be;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        v0, w0, resp0, ready0, mr0, mw0, rv0, err0;
    logic [2:0]  f0;
    logic [31:0] a0, wd0, rd0, ma0, mwd0, rr0;
    logic [3:0]  be0;

    logic        v1, w1, resp1, ready1, mr1, mw1, rv1, err1;
    logic [2:0]  f1;
    logic [63:0] a1, wd1, rd1, ma1, mwd1, rr1;
    logic [7:0]  be1;

    mem_access_unit #(.XLEN(32)) u32 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(ready0), .req_write(w0),
        .req_funct3(f0), .req_addr(a0), .req_wdata(wd0), .mem_address(ma0),
        .mem_wdata(mwd0), .mem_byte_enable(be0), .mem_read(mr0), .mem_write(mw0),
        .mem_rdata(rd0), .mem_resp(resp0), .rsp_valid(rv0), .rsp_rdata(rr0), .rsp_err(err0)
    );

    mem_access_unit #(.XLEN(64), .TIMEOUT(TO64)) u64 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(ready1), .req_write(w1),
        .req_funct3(f1), .req_addr(a1), .req_wdata(wd1), .mem_address(ma1),
        .mem_wdata(mwd1), .mem_byte_enable(be1), .mem_read(mr1), .mem_write(mw1),
        .mem_rdata(rd1), .mem_resp(resp1), .rsp_valid(rv1), .rsp_rdata(rr1), .rsp_err(err1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int d, input logic v, input logic wr, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] wd);
        if (d == 0) begin
            v0 = v; w0 = wr; f0 = f3; a0 = addr[31:0]; wd0 = wd[31:0];
        end else begin
            v1 = v; w1 = wr; f1 = f3; a1 = addr; wd1 = wd;
        end
    endtask

    task automatic drive_mem(input int d, input logic resp, input logic [63:0] rd);
        if (d == 0) begin
            resp0 = resp; rd0 = rd[31:0];
        end else begin
            resp1 = resp; rd1 = rd;
        end
    endtask

    function automatic obs_t sample(input int d);
        obs_t o;
        if (d == 0) begin
            o = '{ready0, mr0, mw0, rv0, err0, {32'd0, ma0}, {32'd0, mwd0}, {32'd0, rr0}, {4'd0, be0}};
        end else begin
            o = '{ready1, mr1, mw1, rv1, err1, ma1, mwd1, rr1, be1};
        end
        return o;
    endfunction

    // Reference rules: which funct3 values are legal for a given width and direction
    function automatic bit is_legal(input int xl, input logic wr, input logic [2:0] f3);
        if (wr) return (f3 <= ((xl == 64) ? 3'd3 : 3'd2));
        if (f3 == 3'b111) return 1'b0;
        if (xl == 32 && (f3 == 3'b011 || f3 == 3'b110)) return 1'b0;
        return 1'b1;
    endfunction

    // One complete access with expectations built byte by byte from the access rules
    task automatic run_access(input int d, input logic wr, input logic [2:0] f3,
                              input logic [63:0] addr_in, input logic [63:0] wd_in,
                              input logic [63:0] rd_in, input int delay, input string tag,
                              output logic [63:0] got_addr, output logic [63:0] got_be,
                              output logic [63:0] got_wdata, output logic [63:0] got_rdata,
                              output logic got_err);
        int xl, nb, sz, off, eoff, to, ncyc;
        bit trap, timed_out;
        logic [63:0] xmask, addr, wd, rd, exp_addr, exp_be, exp_wd, exp_ld;
        obs_t o;
        xl    = (d == 0) ? 32 : 64;
        to    = (d == 0) ? 255 : int'(TO64);
        nb    = xl / 8;
        xmask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        addr  = addr_in & xmask;
        wd    = wd_in & xmask;
        rd    = rd_in & xmask;
        sz    = 1 << f3[1:0];
        off   = int'(addr % 64'(nb));
        eoff  = off - (off % sz);
        trap  = !is_legal(xl, wr, f3);
`ifdef MEM_MISALIGN_TRAP_EN
        if (off % sz != 0) trap = 1'b1;
`endif
        exp_addr = addr - 64'(off);
        exp_be   = ((64'd1 << sz) - 64'd1) << eoff;
        exp_wd   = (wd << (8 * eoff)) & xmask;
        exp_ld   = '0;
        if (!trap) begin
            for (int i = 0; i < sz; i++) exp_ld[8*i +: 8] = rd[8*(eoff+i) +: 8];
            if (!f3[2] && exp_ld[8*sz-1])
                for (int i = sz; i < nb; i++) exp_ld[8*i +: 8] = 8'hFF;
        end
        got_addr = '0; got_be = '0; got_wdata = '0;

        o = sample(d);
        check({tag, ".ready"}, 64'(o.ready), 64'd1);
        drive_req(d, 1'b1, wr, f3, addr, wd);
        @(negedge clk);
        drive_req(d, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        if (trap) begin
            o = sample(d);
            check({tag, ".trap_rv"}, 64'(o.rv), 64'd1);
            check({tag, ".trap_strobe"}, 64'({o.rd, o.wr}), 64'd0);
        end else begin
            timed_out = (to != 0) && (delay > to);
            ncyc = timed_out ? to : delay;
            for (int c = 1; c <= ncyc; c++) begin
                o = sample(d);
                if (c == 1) begin
                    got_addr = o.addr; got_be = 64'(o.be); got_wdata = o.wdata;
                end
                check({tag, ".strobe"}, 64'({o.rd, o.wr}), 64'({!wr, wr}));
                check({tag, ".addr"}, o.addr, exp_addr);
                check({tag, ".be"}, 64'(o.be), exp_be);
                if (wr) check({tag, ".wdata"}, o.wdata, exp_wd);
                check({tag, ".early_rv"}, 64'(o.rv), 64'd0);
                if (!timed_out && c == delay) drive_mem(d, 1'b1, rd);
                @(negedge clk);
                drive_mem(d, 1'b0, {$urandom, $urandom});
            end
            o = sample(d);
            check({tag, ".rv"}, 64'(o.rv), 64'd1);
            check({tag, ".end_strobe"}, 64'({o.rd, o.wr}), 64'd0);
            check({tag, ".err"}, 64'(o.err), 64'(timed_out));
        end
        check({tag, ".rdata"}, o.rdata, (trap || wr || (!trap && (to != 0) && (delay > to))) ? 64'd0 : exp_ld);
        if (trap) check({tag, ".trap_err"}, 64'(o.err), 64'd1);
        got_rdata = o.rdata;
        got_err   = o.err;
        @(negedge clk);
        o = sample(d);
        check({tag, ".pulse"}, 64'(o.rv), 64'd0);
        check({tag, ".ready_after"}, 64'(o.ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        obs_t o;
        logic [63:0] ga, gb, gw, gr;
        logic ge;
        rst = 1'b0;
        drive_req(0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        drive_req(1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        drive_mem(0, 1'b0, 64'd0);
        drive_mem(1, 1'b0, 64'd0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            o = sample(d);
            check("rst.ready", 64'(o.ready), 64'd1);
            check("rst.flags", 64'({o.rd, o.wr, o.rv, o.err}), 64'd0);
            check("rst.data", o.addr | o.wdata | o.rdata | 64'(o.be), 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        run_access(0, 1'b0, 3'b000, 64'h103, 64'd0, 64'h80FF_FF7F, 1, "lb", ga, gb, gw, gr, ge);
        check("lb.addr_lit", ga, 64'h100);
        check("lb.be_lit", gb, 64'h8);
        check("lb.rdata_lit", gr, 64'hFFFF_FF80);

        run_access(0, 1'b1, 3'b001, 64'h22, 64'h0000_BEEF, 64'd0, 5, "sh", ga, gb, gw, gr, ge);
        check("sh.be_lit", gb, 64'hC);
        check("sh.wdata_lit", gw, 64'hBEEF_0000);

        run_access(0, 1'b0, 3'b010, 64'h41, 64'd0, 64'h1234_5678, 2, "lw41", ga, gb, gw, gr, ge);
`ifdef MEM_MISALIGN_TRAP_EN
        check("lw41.err_lit", 64'(ge), 64'd1);
`else
        check("lw41.addr_lit", ga, 64'h40);
        check("lw41.be_lit", gb, 64'hF);
        check("lw41.err_lit", 64'(ge), 64'd0);
`endif

        run_access(1, 1'b0, 3'b010, 64'h10, 64'd0, 64'h1, 100, "timeout", ga, gb, gw, gr, ge);
        check("timeout.err_lit", 64'(ge), 64'd1);
        check("timeout.rdata_lit", gr, 64'd0);
        run_access(1, 1'b0, 3'b011, 64'h18, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 4, "expiry_resp",
                   ga, gb, gw, gr, ge);
        check("expiry_resp.err_lit", 64'(ge), 64'd0);
        check("expiry_resp.rdata_lit", gr, 64'hDEAD_BEEF_0BAD_F00D);

        run_access(1, 1'b0, 3'b110, 64'h4, 64'd0, 64'h8765_4321_0000_0000, 1, "lwu64",
                   ga, gb, gw, gr, ge);
        check("lwu64.be_lit", gb, 64'hF0);
        check("lwu64.rdata_lit", gr, 64'h0000_0000_8765_4321);

        run_access(0, 1'b0, 3'b011, 64'h8, 64'd0, 64'd0, 1, "ld32", ga, gb, gw, gr, ge);
        check("ld32.err_lit", 64'(ge), 64'd1);

        // mem_resp while idle must not produce a response
        drive_mem(0, 1'b1, 64'h55);
        @(negedge clk);
        drive_mem(0, 1'b0, 64'd0);
        o = sample(0);
        check("idle_resp.rv", 64'(o.rv), 64'd0);
        check("idle_resp.ready", 64'(o.ready), 64'd1);

        // Reset in the middle of an access
        drive_req(0, 1'b1, 1'b0, 3'b010, 64'h80, 64'd0);
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        o = sample(0);
        check("mid_rst.read_before", 64'(o.rd), 64'd1);
        #2 rst = 1'b0;
        #1 o = sample(0);
        check("mid_rst.read_async", 64'(o.rd), 64'd0);
        check("mid_rst.rv", 64'(o.rv), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        o = sample(0);
        check("mid_rst.ready", 64'(o.ready), 64'd1);
        @(negedge clk);
        o = sample(0);
        check("mid_rst.no_rv", 64'(o.rv), 64'd0);
        run_access(0, 1'b0, 3'b100, 64'h2, 64'd0, 64'h00AB_0000, 1, "lbu_after_rst",
                   ga, gb, gw, gr, ge);
        check("lbu_after_rst.rdata_lit", gr, 64'h0000_00AB);

        for (int n = 0; n < 160; n++) begin
            int d;
            d = n % 2;
            run_access(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                       int'($urandom_range(1, 7)), (d == 0) ? "rnd32" : "rnd64",
                       ga, gb, gw, gr, ge);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store unit for the multicycle RV32I core; replaces the fixed-width MAR/MDR/data-out register path and the hard-wired lb/lbu/lh/lhu regfile-mux inputs. Control issues one access per request through a valid/ready handshake. The unit drives the memory port with an aligned address, byte enables and lane-shifted write data, waits for `mem_resp`, then returns sign- or zero-extended load data plus an error flag. Sits between control/datapath and the cache/memory port.

## Interface
- `XLEN`, 32: data/address width; legal values 32 or 64.
- `TIMEOUT`, 255: max ACCESS cycles without `mem_resp` before abort; 0 disables the timeout.
- `clk` in 1: clock.
- `rst` in 1: reset; one clock, reset asynchronous and active-low.
- `req_valid` in 1: access request from control.
- `req_ready` out 1: high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD).
- `req_addr` in XLEN: byte address (ALU output).
- `req_wdata` in XLEN: store data (rs2), unshifted.
- `mem_address` out XLEN: address with low log2(XLEN/8) bits cleared.
- `mem_wdata` out XLEN: store data shifted to its byte lane.
- `mem_byte_enable` out XLEN/8: active lanes.
- `mem_read`, `mem_write` out 1: memory strobes.
- `mem_rdata` in XLEN; `mem_resp` in 1: memory data and completion.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `rsp_err` out 1: qualified by `rsp_valid`; illegal funct3, misalignment, or timeout.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch request. Legal → ACCESS. Illegal → RESP with err; no memory strobe.
- Illegal funct3: store funct3 > 3; LD/LWU/SD when XLEN=32; load funct3 3'b111.
- Lane offset `off` = addr[log2(XLEN/8)-1:0]. Size is 1/2/4/8 bytes from funct3[1:0]. Enables = ((1<<size)-1) << off. `mem_wdata` = wdata << (8*off).
- ACCESS: exactly one strobe held high. Address, enables and wdata are held stable until `mem_resp`. On `mem_resp`: extract `mem_rdata >> 8*off`, truncate to size, sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU, LD full), register the result, strobes low → RESP.
- Timeout: a counter clears on ACCESS entry. If `TIMEOUT` != 0 and the counter reaches `TIMEOUT` without `mem_resp`, drop strobes, go to RESP with err and rdata 0. If `mem_resp` arrives on the same cycle as expiry, the response wins with no error.
- RESP: `rsp_valid`=1 for exactly one cycle → IDLE. A new request is accepted on the following cycle.
- `mem_resp` outside ACCESS is ignored.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `req_ready`=1, all other outputs 0.
- Reset asserted mid-ACCESS: strobes drop immediately (asynchronously) and the transaction is abandoned. No `rsp_valid` is produced.
- Latency: accept at cycle 0; strobe high from cycle 1. `mem_resp` sampled in cycle k≥1 gives `rsp_valid` in cycle k+1. Minimum 2 cycles.
- Error with no access: `rsp_valid` at cycle 1.
- Throughput: one access per k+2 cycles; no pipelining.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: an access with `off` not a multiple of its size (or crossing the XLEN boundary) goes IDLE→RESP with `rsp_err`=1. No strobe.
- Undefined: `off` is rounded down to a multiple of size before lane computation. The access proceeds with no error.

## Test plan
- LB, XLEN=32, addr 0x103, `mem_rdata` 0x80FF_FF7F → `mem_address` 0x100, enables 4'b1000, `rsp_rdata` 0xFFFF_FF80, err 0.
- SH, addr 0x22, wdata 0x0000_BEEF → `mem_write`=1, enables 4'b1100, `mem_wdata` 0xBEEF_0000. Strobe held for 5 cycles of delayed `mem_resp`; `rsp_valid` is a single pulse.
- LW, addr 0x41:
  - with `MEM_MISALIGN_TRAP_EN`: no `mem_read`, `rsp_valid`+`rsp_err` at cycle 1.
  - without it: address 0x40, enables 4'b1111.
- `TIMEOUT`=4, `mem_resp` never asserted → `mem_read` high 4 cycles, then `rsp_err`=1, `rsp_rdata`=0. Also check `mem_resp` landing exactly on the expiry cycle → err 0.
- `rst` low during ACCESS → `mem_read` 0 asynchronously, no `rsp_valid`, `req_ready`=1 after release. The next LBU from 0x2 returns 0x0000_00AB for `mem_rdata` 0x00AB_0000.
- XLEN=64, LWU addr 0x4, `mem_rdata` 0x8765_4321_0000_0000 → enables 8'hF0, `rsp_rdata` 0x0000_0000_8765_4321. LD at XLEN=32 → `rsp_err`=1.
